// File: rtl/serv_ibus_pkg.sv
// Shared definitions for the instruction-bus ROM responder: FSM state
// encoding and the width of the wait-state counter.
package serv_ibus_pkg;

    // Fetch state machine encoding (3-bit, values fixed for debug visibility).
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD0   = 3'd1,
        RD1   = 3'd2,
        STALL = 3'd3,
        ACK   = 3'd4
    } ibus_state_t;

    // Width of the stall counter; supports WAIT_STATES up to 15.
    localparam int CNT_W = 4;

endpackage : serv_ibus_pkg

// File: rtl/serv_ibus_ram.sv
// Instruction memory: one synchronous read port and one write port.
// A read and write to the same word in the same cycle returns the old data.
// Contents are deliberately not reset.
module serv_ibus_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_adr,
    output logic [31:0]       o_rd_dat,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_adr,
    input  logic [31:0]       i_wr_dat
);

    logic [31:0] r_mem [0:(2**ADDR_W)-1];
    logic [31:0] r_rd_dat;

    // Memory array update and read-first registered read port.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_adr] <= i_wr_dat;
        end
        if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_adr];
        end
    end

    assign o_rd_dat = r_rd_dat;

endmodule : serv_ibus_ram

// File: rtl/serv_ibus_rom.sv
// Wishbone-classic instruction-bus responder for the bit-serial core.
// Serves word-aligned fetches in one memory read and halfword-aligned
// (RVC) fetches by splicing the upper half of word W with the lower half
// of word W+1. Optional wait states delay every acknowledge.
module serv_ibus_rom
    import serv_ibus_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic [31:0]       i_ibus_adr,
    input  logic              i_ibus_cyc,
    output logic [31:0]       o_ibus_rdt,
    output logic              o_ibus_ack,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_adr,
    input  logic [31:0]       i_wr_dat
);

    // Last stall-count value before moving to ACK (unused when no wait states).
    localparam int              LP_LAST_I     = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
    localparam logic [CNT_W-1:0] LP_STALL_LAST = LP_LAST_I[CNT_W-1:0];

    ibus_state_t       r_state;
    logic [ADDR_W-1:0] r_word;
    logic              r_half;
    logic [CNT_W-1:0]  r_cnt;
    logic [31:0]       r_rdt;
    logic              r_ack;

    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_adr;
    logic [31:0]       w_rd_dat;
    logic [ADDR_W-1:0] w_word_nxt;
    logic              w_unused;

    // Second word of a misaligned fetch; wraps naturally at the memory depth.
    assign w_word_nxt = r_word + {{(ADDR_W-1){1'b0}}, 1'b1};

    // High address bits alias and byte-offset bit 0 is meaningless for fetches.
    assign w_unused = ^{i_ibus_adr[31:ADDR_W+2], i_ibus_adr[0]};

    // Memory read request: first word straight off the bus in IDLE, W+1 in RD0.
    always_comb begin
        w_rd_en  = 1'b0;
        w_rd_adr = {ADDR_W{1'b0}};
        case (r_state)
            IDLE: begin
                w_rd_en  = i_ibus_cyc;
                w_rd_adr = i_ibus_adr[ADDR_W+1:2];
            end
            RD0: begin
                w_rd_en  = r_half;
                w_rd_adr = w_word_nxt;
            end
            default: begin
                w_rd_en  = 1'b0;
                w_rd_adr = {ADDR_W{1'b0}};
            end
        endcase
    end

    // Fetch sequencer with registered data and acknowledge outputs.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_word  <= {ADDR_W{1'b0}};
            r_half  <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
            r_rdt   <= 32'h0000_0000;
            r_ack   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= 1'b0;
                    if (i_ibus_cyc) begin
                        r_word  <= i_ibus_adr[ADDR_W+1:2];
                        r_half  <= i_ibus_adr[1];
                        r_state <= RD0;
                    end
                end
                RD0: begin
                    if (!i_ibus_cyc) begin
                        r_state <= IDLE;
                    end else if (r_half) begin
                        r_rdt[15:0] <= w_rd_dat[31:16];
                        r_state     <= RD1;
                    end else begin
                        r_rdt <= w_rd_dat;
                        if (WAIT_STATES == 0) begin
                            r_state <= ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= STALL;
                            r_cnt   <= {CNT_W{1'b0}};
                        end
                    end
                end
                RD1: begin
                    if (!i_ibus_cyc) begin
                        r_state <= IDLE;
                    end else begin
                        r_rdt[31:16] <= w_rd_dat[15:0];
                        if (WAIT_STATES == 0) begin
                            r_state <= ACK;
                            r_ack   <= 1'b1;
                        end else begin
                            r_state <= STALL;
                            r_cnt   <= {CNT_W{1'b0}};
                        end
                    end
                end
                STALL: begin
                    if (!i_ibus_cyc) begin
                        r_state <= IDLE;
                        r_cnt   <= {CNT_W{1'b0}};
                    end else if (r_cnt == LP_STALL_LAST) begin
                        r_state <= ACK;
                        r_ack   <= 1'b1;
                        r_cnt   <= {CNT_W{1'b0}};
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ACK: begin
                    r_ack   <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_cnt   <= {CNT_W{1'b0}};
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_ibus_rdt = r_rdt;
    assign o_ibus_ack = r_ack;

    serv_ibus_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .i_rd_en  (w_rd_en),
        .i_rd_adr (w_rd_adr),
        .o_rd_dat (w_rd_dat),
        .i_wr_en  (i_wr_en),
        .i_wr_adr (i_wr_adr),
        .i_wr_dat (i_wr_dat)
    );

endmodule : serv_ibus_rom

// File: tb/tb_serv_ibus_rom.sv
// Directed bench for serv_ibus_rom: three instances (default, 4-bit address,
// three wait states) share the clock, reset, address and write bus; each has
// its own cyc line so only one is fetching at a time.
module tb_serv_ibus_rom;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr;
    logic [2:0]  cyc;
    logic [2:0]  ack;
    logic [31:0] rdt [3];
    logic        wr_en;
    logic [9:0]  wr_adr;
    logic [31:0] wr_dat;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serv_ibus_rom #(.ADDR_W(10), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .i_rst_n(rst_n), .i_ibus_adr(adr), .i_ibus_cyc(cyc[0]),
        .o_ibus_rdt(rdt[0]), .o_ibus_ack(ack[0]),
        .i_wr_en(wr_en), .i_wr_adr(wr_adr), .i_wr_dat(wr_dat)
    );

    serv_ibus_rom #(.ADDR_W(4), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .i_rst_n(rst_n), .i_ibus_adr(adr), .i_ibus_cyc(cyc[1]),
        .o_ibus_rdt(rdt[1]), .o_ibus_ack(ack[1]),
        .i_wr_en(wr_en), .i_wr_adr(wr_adr[3:0]), .i_wr_dat(wr_dat)
    );

    serv_ibus_rom #(.ADDR_W(10), .WAIT_STATES(3)) u_dut2 (
        .clk(clk), .i_rst_n(rst_n), .i_ibus_adr(adr), .i_ibus_cyc(cyc[2]),
        .o_ibus_rdt(rdt[2]), .o_ibus_ack(ack[2]),
        .i_wr_en(wr_en), .i_wr_adr(wr_adr), .i_wr_dat(wr_dat)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called #1 after a rising edge; leaves the bench at the same phase.
    task automatic mem_wr(input logic [9:0] a, input logic [31:0] d);
        wr_en  = 1'b1;
        wr_adr = a;
        wr_dat = d;
        @(posedge clk); #1;
        wr_en  = 1'b0;
    endtask

    // Issue a fetch in the current cycle N; lat is k for an ack in N+k, -1 on timeout.
    task automatic fetch(input int d, input logic [31:0] a,
                         output logic [31:0] data, output int lat);
        cyc[d] = 1'b1;
        adr    = a;
        lat    = -1;
        data   = 32'h0;
        for (int k = 1; k <= 25 && lat < 0; k++) begin
            @(posedge clk); #1;
            wr_en = 1'b0;
            if (ack[d]) begin
                lat    = k;
                data   = rdt[d];
                cyc[d] = 1'b0;
            end
        end
        cyc[d] = 1'b0;
        @(posedge clk); #1;
        check_eq("ack_one_cycle", {31'b0, ack[d]}, 32'h0);
    endtask

    logic [31:0] data;
    int          lat;
    logic        seen;

    initial begin
        rst_n  = 1'b0;
        cyc    = 3'b000;
        adr    = 32'h0;
        wr_en  = 1'b0;
        wr_adr = 10'h0;
        wr_dat = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_ack0", {31'b0, ack[0]}, 32'h0);
        check_eq("reset_rdt0", rdt[0], 32'h0);
        check_eq("reset_ack2", {31'b0, ack[2]}, 32'h0);
        rst_n = 1'b1;

        // Aligned fetch, no wait states.
        mem_wr(10'd4, 32'h00A0_0093);
        fetch(0, 32'h10, data, lat);
        check_eq("aligned_data", data, 32'h00A0_0093);
        check_eq("aligned_lat", lat, 32'd2);

        // Misaligned fetch splices mem[5][15:0] over mem[4][31:16].
        mem_wr(10'd4, 32'h4505_1111);
        mem_wr(10'd5, 32'h2222_8082);
        fetch(0, 32'h12, data, lat);
        check_eq("misaligned_data", data, 32'h8082_4505);
        check_eq("misaligned_lat", lat, 32'd3);

        // Wrap and alias with a 16-word memory.
        mem_wr(10'd15, 32'hAAAA_0000);
        mem_wr(10'd0, 32'h0000_BBBB);
        fetch(1, 32'h3E, data, lat);
        check_eq("wrap_data", data, 32'hBBBB_AAAA);
        check_eq("wrap_lat", lat, 32'd3);
        fetch(1, 32'h40, data, lat);
        check_eq("alias_data", data, 32'h0000_BBBB);
        check_eq("alias_lat", lat, 32'd2);

        // Three wait states.
        mem_wr(10'd4, 32'h00A0_0093);
        fetch(2, 32'h10, data, lat);
        check_eq("ws3_data", data, 32'h00A0_0093);
        check_eq("ws3_lat", lat, 32'd5);

        // Abort in RD1: no ack, then a normal fetch.
        cyc[0] = 1'b1;
        adr    = 32'h12;
        @(posedge clk); #1;
        seen = ack[0];
        @(posedge clk); #1;
        seen   = seen | ack[0];
        cyc[0] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            seen = seen | ack[0];
        end
        check_eq("abort_no_ack", {31'b0, seen}, 32'h0);
        fetch(0, 32'h12, data, lat);
        check_eq("post_abort_data", data, 32'h8082_00A0);
        check_eq("post_abort_lat", lat, 32'd3);

        // Reset while stalling clears outputs immediately.
        cyc[2] = 1'b1;
        adr    = 32'h10;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("pre_reset_rdt", rdt[2], 32'h00A0_0093);
        rst_n  = 1'b0;
        cyc[2] = 1'b0;
        #1;
        check_eq("async_reset_ack", {31'b0, ack[2]}, 32'h0);
        check_eq("async_reset_rdt", rdt[2], 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        fetch(0, 32'h10, data, lat);
        check_eq("post_reset_data", data, 32'h00A0_0093);
        check_eq("post_reset_lat", lat, 32'd2);
        fetch(2, 32'h10, data, lat);
        check_eq("post_reset_ws3_data", data, 32'h00A0_0093);
        check_eq("post_reset_ws3_lat", lat, 32'd5);

        // Read/write collision on word 4: read-first, write retained.
        mem_wr(10'd4, 32'h0000_0000);
        wr_en  = 1'b1;
        wr_adr = 10'd4;
        wr_dat = 32'h1234_5678;
        fetch(0, 32'h10, data, lat);
        check_eq("collide_old_data", data, 32'h0000_0000);
        check_eq("collide_lat", lat, 32'd2);
        fetch(0, 32'h10, data, lat);
        check_eq("collide_new_data", data, 32'h1234_5678);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule : tb_serv_ibus_rom
